// File: rtl/country_sensor.sv
// Country-road vehicle sensor: synchronizes and debounces an inductive-loop
// detector, keeps a queue of waiting vehicles, and raises a request to the controller.
module country_sensor #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned DEPART_CYCLES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             det_raw,
  input  logic [1:0]       cntry,
  output logic             x,
  output logic [CNT_W-1:0] queue_cnt,
  output logic             ovf,
  output logic             bad_state
);

  typedef enum logic [1:0] {
    CNTRY_RED    = 2'd0,
    CNTRY_YELLOW = 2'd1,
    CNTRY_GREEN  = 2'd2,
    CNTRY_BAD    = 2'd3
  } cntry_e;

  localparam logic [3:0]       DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [7:0]       DEP_LAST = 8'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] Q_MAX    = '1;

  logic             s1, s2;
  logic             level, level_nxt;
  logic [3:0]       deb_cnt, deb_nxt;
  logic [7:0]       timer, timer_nxt;
  logic [CNT_W-1:0] q_nxt;
  logic             ovf_nxt;
  logic             arrival, depart;

  always_comb begin
    deb_nxt   = '0;
    level_nxt = level;
    arrival   = 1'b0;
    if (s2 != level) begin
      if (deb_cnt == DEB_LAST) begin
        // The edge that would reach DEB_CYCLES toggles the level instead.
        level_nxt = ~level;
        arrival   = ~level;
      end else begin
        deb_nxt = deb_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    timer_nxt = '0;
    depart    = 1'b0;
    if (cntry == CNTRY_GREEN && queue_cnt != '0) begin
      if (timer == DEP_LAST) depart = 1'b1;
      else timer_nxt = timer + 8'd1;
    end
  end

  always_comb begin
    q_nxt   = queue_cnt;
    ovf_nxt = ovf;
    if (arrival && !depart) begin
      if (queue_cnt == Q_MAX) ovf_nxt = 1'b1;
      else q_nxt = queue_cnt + CNT_W'(1);
    end else if (depart && !arrival) begin
      q_nxt = queue_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      level     <= 1'b0;
      deb_cnt   <= '0;
      timer     <= '0;
      queue_cnt <= '0;
      ovf       <= 1'b0;
      bad_state <= 1'b0;
    end else begin
      s1        <= det_raw;
      s2        <= s1;
      level     <= level_nxt;
      deb_cnt   <= deb_nxt;
      timer     <= timer_nxt;
      queue_cnt <= q_nxt;
      ovf       <= ovf_nxt;
      bad_state <= bad_state | (cntry == CNTRY_BAD);
    end
  end

  assign x = (queue_cnt != '0);

endmodule

// File: tb/tb_country_sensor.sv
// Bench for country_sensor: directed scenarios plus random detector/light
// traffic, all compared against a rule-level queue model.
module tb_country_sensor;

  localparam int DEB    = 4;
  localparam int DEPART = 8;
  localparam int CW     = 4;
  localparam int QMAX   = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          det_raw = 1'b1;
  logic [1:0]    cntry = 2'd2;
  logic          x;
  logic [CW-1:0] queue_cnt;
  logic          ovf;
  logic          bad_state;

  int n_checks = 0;
  int n_fail   = 0;

  country_sensor #(.DEB_CYCLES(DEB), .DEPART_CYCLES(DEPART), .CNT_W(CW)) dut (
    .clock(clock), .clear(clear), .det_raw(det_raw), .cntry(cntry),
    .x(x), .queue_cnt(queue_cnt), .ovf(ovf), .bad_state(bad_state)
  );

  always #5 clock = ~clock;

  // Reference model: detector samples reach the debouncer two edges late; a
  // level change is accepted after DEB consecutive differing samples; a car
  // departs after every DEPART consecutive green edges with a non-empty queue.
  bit m_pipe[$];
  bit m_lvl;
  int m_run, m_green, m_q;
  bit m_ovf, m_bad;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe = {1'b0, 1'b0};
    m_lvl = 0; m_run = 0; m_green = 0; m_q = 0; m_ovf = 0; m_bad = 0;
  endtask

  task automatic model_edge(input bit det, input logic [1:0] cn);
    bit synced, arrive, dep;
    synced = m_pipe.pop_front();
    m_pipe.push_back(det);
    arrive = 0;
    if (synced != m_lvl) begin
      m_run++;
      if (m_run == DEB) begin
        m_lvl = synced; m_run = 0; arrive = synced;
      end
    end else m_run = 0;
    dep = 0;
    if (cn == 2'd2 && m_q > 0) begin
      m_green++;
      if (m_green == DEPART) begin dep = 1; m_green = 0; end
    end else m_green = 0;
    if (arrive && !dep) begin
      if (m_q == QMAX) m_ovf = 1; else m_q++;
    end else if (dep && !arrive) m_q--;
    if (cn == 2'd3) m_bad = 1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".queue_cnt"}, int'(queue_cnt), m_q);
    check({tag, ".x"}, int'(x), int'(m_q != 0));
    check({tag, ".ovf"}, int'(ovf), int'(m_ovf));
    check({tag, ".bad_state"}, int'(bad_state), int'(m_bad));
  endtask

  task automatic cycle(input bit det, input logic [1:0] cn, input string tag);
    @(negedge clock);
    det_raw = det;
    cntry   = cn;
    @(posedge clock);
    if (!clear) model_reset();
    else model_edge(det, cn);
    #1 compare_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".queue_cnt"}, int'(queue_cnt), 0);
    check({tag, ".x"}, int'(x), 0);
    check({tag, ".ovf"}, int'(ovf), 0);
    check({tag, ".bad_state"}, int'(bad_state), 0);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2 clear = 1'b1;
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2 clear = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
  endtask

  task automatic pulse(input int hi, input int lo, input logic [1:0] cn, input string tag);
    for (int i = 0; i < hi; i++) cycle(1'b1, cn, tag);
    for (int i = 0; i < lo; i++) cycle(1'b0, cn, tag);
  endtask

  initial begin
    bit det;
    logic [1:0] cn;
    int r;
    model_reset();

    // Reset held with detector high and light green.
    #2 check_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd2, "rst_hold");
      check_zero("rst_hold_z");
    end
    release_reset();

    // Single car across reset release: arrival on the 6th edge.
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 2'd0, "single");
      check("single_lat", int'(queue_cnt), (i >= DEB + 2) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 2'd0, "single_fall");

    // Glitch shorter than the debounce window.
    pulse(3, 8, 2'd0, "glitch");
    check("glitch_q", int'(queue_cnt), 1);

    // Two more cars, then departures with a yellow interruption.
    pulse(6, 6, 2'd0, "fill3");
    pulse(6, 6, 2'd0, "fill3");
    check("fill3_q", int'(queue_cnt), 3);
    for (int i = 1; i <= 11; i++) begin
      cycle(1'b0, 2'd2, "dep1");
      if (i == 7) check("dep_pre8", int'(queue_cnt), 3);
      if (i == 8) check("dep_edge8", int'(queue_cnt), 2);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd1, "dep_yel");
    for (int i = 1; i <= 8; i++) cycle(1'b0, 2'd2, "dep2");
    check("dep_after_yel", int'(queue_cnt), 1);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 2'd2, "dep3");
    check("dep_empty_q", int'(queue_cnt), 0);
    check("dep_empty_x", int'(x), 0);

    // Saturation.
    for (int k = 0; k < QMAX + 2; k++) pulse(6, 6, 2'd0, "sat");
    check("sat_q", int'(queue_cnt), QMAX);
    check("sat_ovf", int'(ovf), 1);

    // Arrival landing on the 8th green edge, coinciding with a departure.
    cycle(1'b0, 2'd2, "simul");
    cycle(1'b0, 2'd2, "simul");
    for (int i = 3; i <= 8; i++) cycle(1'b1, 2'd2, "simul");
    check("simul_q", int'(queue_cnt), QMAX);
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'd0, "simul_fall");

    // Invalid light state clears the departure timer.
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'd2, "bad_pre");
    cycle(1'b0, 2'd3, "bad");
    check("bad_flag", int'(bad_state), 1);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 2'd2, "bad_post");
      if (i == 7) check("bad_timer_pre", int'(queue_cnt), QMAX);
    end
    check("bad_timer", int'(queue_cnt), QMAX - 1);

    // Drain to 5 then reset mid-run.
    for (int i = 0; i < 9 * DEPART; i++) cycle(1'b0, 2'd2, "drain");
    check("drain_q", int'(queue_cnt), 5);
    async_reset();
    cycle(1'b0, 2'd2, "mid_rst");
    release_reset();

    // Random traffic with occasional asynchronous resets.
    det = 0;
    cn  = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        release_reset();
      end else begin
        if ($urandom_range(0, 4) == 0) det = ~det;
        if ($urandom_range(0, 14) == 0) begin
          r  = $urandom_range(0, 15);
          cn = (r == 15) ? 2'd3 : 2'(r % 3);
        end
        cycle(det, cn, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/country_sensor.md
COUNTRY_SENSOR -- requirements
Module: country_sensor

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive synchronized samples needed to accept a detector level change (range 2..15).
REQ-002 Parameter DEPART_CYCLES, default 8: clock cycles of country green per departing vehicle (range 2..255).
REQ-003 Parameter CNT_W, default 4: width of the vehicle queue counter.
REQ-004 clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 clear  input  1  asynchronous, active-low reset.
REQ-006 det_raw  input  1  raw inductive-loop detector, asynchronous to clock, high while a vehicle is over the loop.
REQ-007 cntry  input  2  country-road light state from the traffic controller: 2'd0 RED, 2'd1 YELLOW, 2'd2 GREEN; 2'd3 is invalid.
REQ-008 x  output  1  vehicle-waiting request to the traffic controller.
REQ-009 queue_cnt  output  CNT_W  number of vehicles currently queued on the country road.
REQ-010 ovf  output  1  sticky flag: an arrival was dropped because the queue was full.
REQ-011 bad_state  output  1  sticky flag: cntry == 2'd3 was sampled.

Function
REQ-012 det_raw shall pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-013 Debounce: the counter shall increment each cycle s2 differs from the debounced level, and clear to 0 when they match.
REQ-014 On the edge where the debounce counter would reach DEB_CYCLES, the debounced level shall toggle and the counter shall clear.
REQ-015 A 0->1 toggle of the debounced level shall be an arrival event; a 1->0 toggle shall have no effect on the queue.
REQ-016 Arrival latency: with det_raw held high, queue_cnt shall change on the (DEB_CYCLES+2)-th rising edge, counting the first edge that samples det_raw high (6th edge at default).
REQ-017 Departure timer: shall count while cntry == GREEN and queue_cnt != 0, and shall clear to 0 in any other cycle.
REQ-018 When the timer reaches DEPART_CYCLES-1, a departure event shall occur and the timer shall return to 0; the first departure falls on the DEPART_CYCLES-th green edge.
REQ-019 Arrival only: queue_cnt+1, saturating at 2^CNT_W-1; an arrival while full shall leave queue_cnt unchanged and set ovf.
REQ-020 Departure only: queue_cnt-1; a departure never occurs at 0, so there is no underflow.
REQ-021 Arrival and departure in the same cycle: queue_cnt unchanged, ovf unchanged, timer still returns to 0.
REQ-022 x shall equal (queue_cnt != 0), decoded from the registered count with no added cycle of delay.
REQ-023 cntry == 2'd3 shall be treated as RED (timer clears) and shall set bad_state on that edge.
REQ-024 ovf and bad_state shall clear only on reset.

Reset
REQ-025 clear low shall immediately force s1, s2, the debounced level, both counters, queue_cnt, x, ovf and bad_state to 0, independent of clock.
REQ-026 After clear rises, state shall first update on the next rising edge; a det_raw held high across reset shall count as one arrival after the REQ-016 latency.
REQ-027 Reset mid-operation shall discard all queued vehicles and timer progress, with no partial event emitted.

Verification
REQ-028 Reset: clear=0 with det_raw=1 and cntry=GREEN -> queue_cnt=0, x=0, ovf=0, bad_state=0, both asynchronously and throughout reset.
REQ-029 Single car, cntry=RED: det_raw high for 10 cycles -> queue_cnt goes 0->1 on edge 6, x=1 from that edge, then stays 1 with no further change.
REQ-030 Glitch rejection: det_raw high for 3 cycles, then low -> queue_cnt stays 0 and x stays 0.
REQ-031 Departure: queue_cnt=3, cntry held GREEN -> decrements on green edges 8, 16 and 24, x=0 after edge 24; cntry->YELLOW at edge 12 -> timer clears and the next decrement occurs 8 green edges after GREEN returns.
REQ-032 Saturation and simultaneity: 16 distinct arrivals with cntry=RED -> queue_cnt=15 and ovf=1; an arrival that coincides with a departure edge -> queue_cnt unchanged.
REQ-033 Invalid state and reset mid-run: cntry=2'd3 for 1 cycle -> bad_state=1 and timer=0; clear pulsed low while queue_cnt=5 -> queue_cnt=0, x=0, bad_state=0 immediately.
